// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the two-way cache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_pkg;

    // Miss-handling sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // lookup; read hits complete here
        ARB  = 2'd1,   // bus requested, waiting for grant
        XFER = 2'd2,   // driving the bus, waiting for the slave
        FILL = 2'd3    // array/LRU update, access completes
    } state_e;

    // Tag width for a given number of set-index bits (addr[1:0] is the byte offset).
    function automatic int tagw(input int index);
        return 32 - index - 2;
    endfunction

    // Number of sets for a given number of set-index bits.
    function automatic int sets(input int index);
        return 1 << index;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bit, tag and one data word per set.
// Latency: read is combinational on set_i, write lands on the next posedge.
// Backpressure: none; the owner decides when we_i is asserted.
//
// Ports:
//   clk, clr   clock and synchronous active-high reset (clears valid bits only)
//   we_i       write the tag/data at set_i and mark the set valid
//   set_i      set index used for both read and write
//   tag_i      tag to store
//   data_i     word to store
//   valid_o    valid bit of set_i
//   tag_o      stored tag of set_i
//   data_o     stored word of set_i
module cache_way
    import cache_pkg::*;
#(
    parameter int INDEX = 6
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        we_i,
    input  logic [INDEX-1:0]            set_i,
    input  logic [31-INDEX-2:0]         tag_i,
    input  logic [31:0]                 data_i,
    output logic                        valid_o,
    output logic [31-INDEX-2:0]         tag_o,
    output logic [31:0]                 data_o
);

    localparam int SETS = sets(INDEX);
    localparam int TAGW = tagw(INDEX);

    logic [SETS-1:0] valid_q;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    // Only the valid bits need clearing; stale tag/data behind a clear
    // valid bit can never produce a hit.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[set_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[set_i]  <= tag_i;
            data_q[set_i] <= data_i;
        end
    end

    assign valid_o = valid_q[set_i];
    assign tag_o   = tag_q[set_i];
    assign data_o  = data_q[set_i];

endmodule

// File: rtl/cache_2way.sv
// Two-way set-associative write-through cache, one word per line, LRU replacement.
// Latency: read hit completes in the lookup cycle; misses, writes and uncached
//          accesses go ARB -> XFER -> FILL and complete in FILL.
// Backpressure: ready low until the access completes; the CPU holds addr_in via stall_in.
//
// Ports:
//   clk, clr              clock, synchronous active-high reset
//   stall_in              holds the address register
//   addr_in/data_in       next access address / write data for the current access
//   req, rw, uncached     access request, 1=write, 1=bypass the arrays
//   data_out, ready       read data and completion for addr_out
//   addr_out              registered current address
//   bus_addr/data/rw      shared tristate bus, driven only while granted in XFER
//   bus_dma               bus request to the arbiter
//   bus_grant, bus_ready  arbiter grant, slave transfer done
//   dbg_*                 internal visibility (write enables, hits, set contents, LRU)
module cache_2way
    import cache_pkg::*;
#(
    parameter int INDEX = 6
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    stall_in,
    input  logic [31:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic                    req,
    input  logic                    rw,
    input  logic                    uncached,
    output logic [31:0]             data_out,
    output logic                    ready,
    output logic [31:0]             addr_out,
    inout  logic [31:0]             bus_addr,
    inout  logic [31:0]             bus_data,
    output logic                    bus_dma,
    inout  logic                    bus_rw,
    input  logic                    bus_grant,
    input  logic                    bus_ready,
    output logic                    dbg_we_a,
    output logic                    dbg_we_b,
    output logic                    dbg_we_c,
    output logic                    dbg_needupdate,
    output logic [31-INDEX-2:0]     dbg_tag,
    output logic                    dbg_hit_a,
    output logic                    dbg_hit_b,
    output logic [31:0]             dbg_ram_a,
    output logic [31:0]             dbg_ram_b,
    output logic                    dbg_lru
);

    localparam int SETS = sets(INDEX);
    localparam int TAGW = tagw(INDEX);

    // ------------------------------------------------------------------
    // Address register
    // ------------------------------------------------------------------
    logic [31:0] addr_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_q <= '0;
        end else if (!stall_in) begin
            addr_q <= addr_in;
        end
    end

    logic [INDEX-1:0] set;
    logic [TAGW-1:0]  tag;

    assign set = addr_q[INDEX+1:2];
    assign tag = addr_q[31:INDEX+2];

    // ------------------------------------------------------------------
    // Ways and lookup
    // ------------------------------------------------------------------
    state_e          state_q;
    logic            bus_dma_q;
    logic            rw_q;
    logic            unc_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [SETS-1:0] lru_q;

    logic            valid_a, valid_b;
    logic [TAGW-1:0] tag_a, tag_b;
    logic [31:0]     ram_a, ram_b;
    logic            we_a, we_b, we_c;
    logic [31:0]     way_wdata;

    // A write hit stores the CPU word; a read fill stores the bus word.
    assign way_wdata = rw_q ? wdata_q : rdata_q;

    cache_way #(.INDEX(INDEX)) u_way_a (
        .clk     (clk),
        .clr     (clr),
        .we_i    (we_a),
        .set_i   (set),
        .tag_i   (tag),
        .data_i  (way_wdata),
        .valid_o (valid_a),
        .tag_o   (tag_a),
        .data_o  (ram_a)
    );

    cache_way #(.INDEX(INDEX)) u_way_b (
        .clk     (clk),
        .clr     (clr),
        .we_i    (we_b),
        .set_i   (set),
        .tag_i   (tag),
        .data_i  (way_wdata),
        .valid_o (valid_b),
        .tag_o   (tag_b),
        .data_o  (ram_b)
    );

    logic hit_a, hit_b, hit;
    logic lru_cur;
    logic victim_b;

    // A fills only the victim, so both ways can never hold the same tag;
    // way A still takes precedence so the two hits stay exclusive by construction.
    assign hit_a   = valid_a && (tag_a == tag);
    assign hit_b   = valid_b && (tag_b == tag) && !hit_a;
    assign hit     = hit_a || hit_b;
    assign lru_cur = lru_q[set];

    // Invalid way first (A before B), otherwise the way the LRU bit names.
    assign victim_b = valid_a && (!valid_b || lru_cur);

    // ------------------------------------------------------------------
    // Array / LRU write enables
    // ------------------------------------------------------------------
    logic read_hit;
    logic in_fill;
    logic fill_cached;
    logic touch_a;

    assign read_hit    = (state_q == IDLE) && req && !rw && !uncached && hit;
    assign in_fill     = (state_q == FILL);
    assign fill_cached = in_fill && !unc_q && !clr;

    // Read fill writes the victim; write hit refreshes the hit way; write miss
    // does not allocate.
    assign we_a = fill_cached && (rw_q ? hit_a : !victim_b);
    assign we_b = fill_cached && (rw_q ? hit_b :  victim_b);

    // LRU moves on every hit (read hit in IDLE, write hit in FILL) and on every fill.
    assign we_c    = (read_hit && !clr) || (fill_cached && (!rw_q || hit));
    // Touching way A makes B the next victim, and vice versa.
    assign touch_a = we_a || (read_hit && hit_a);

    always_ff @(posedge clk) begin
        if (clr) begin
            lru_q <= '0;
        end else if (we_c) begin
            lru_q[set] <= touch_a;
        end
    end

    // ------------------------------------------------------------------
    // Miss / write / bypass sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            bus_dma_q <= 1'b0;
            rw_q      <= 1'b0;
            unc_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Everything except a cached read hit needs the bus.
                    if (req && (rw || uncached || !hit)) begin
                        state_q   <= ARB;
                        bus_dma_q <= 1'b1;
                        rw_q      <= rw;
                        unc_q     <= uncached;
                        wdata_q   <= data_in;
                    end
                end
                ARB: begin
                    if (bus_grant) begin
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        if (!rw_q) begin
                            rdata_q <= bus_data;
                        end
                        bus_dma_q <= 1'b0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tristate bus drivers
    // ------------------------------------------------------------------
    logic drive;

    assign drive    = (state_q == XFER) && bus_grant;
    assign bus_addr = drive ? addr_q : 32'bz;
    assign bus_rw   = drive ? rw_q : 1'bz;
    assign bus_data = (drive && rw_q) ? wdata_q : 32'bz;
    assign bus_dma  = bus_dma_q;

    // ------------------------------------------------------------------
    // CPU side
    // ------------------------------------------------------------------
    always_comb begin
        data_out = '0;
        if (in_fill) begin
            data_out = rdata_q;
        end else if (hit_a) begin
            data_out = ram_a;
        end else if (hit_b) begin
            data_out = ram_b;
        end
    end

    assign ready    = !req || read_hit || in_fill;
    assign addr_out = addr_q;

    // ------------------------------------------------------------------
    // Debug visibility
    // ------------------------------------------------------------------
    assign dbg_we_a       = we_a;
    assign dbg_we_b       = we_b;
    assign dbg_we_c       = we_c;
    assign dbg_needupdate = (state_q != IDLE);
    assign dbg_tag        = tag;
    assign dbg_hit_a      = hit_a;
    assign dbg_hit_b      = hit_b;
    assign dbg_ram_a      = ram_a;
    assign dbg_ram_b      = ram_b;
    assign dbg_lru        = lru_cur;

endmodule

// File: tb/tb_cache_2way.sv
module tb_cache_2way;

    logic        clk;
    logic        clr;
    logic        stall_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        req;
    logic        rw;
    logic        uncached;
    logic [31:0] data_out;
    logic        ready;
    logic [31:0] addr_out;
    wire  [31:0] bus_addr;
    wire  [31:0] bus_data;
    logic        bus_dma;
    wire         bus_rw;
    logic        bus_grant;
    logic        bus_ready;
    logic        dbg_we_a, dbg_we_b, dbg_we_c, dbg_needupdate;
    logic [28:0] dbg_tag;
    logic        dbg_hit_a, dbg_hit_b;
    logic [31:0] dbg_ram_a, dbg_ram_b;
    logic        dbg_lru;

    int checks = 0;
    int errors = 0;

    cache_2way #(.INDEX(1)) dut (
        .clk            (clk),
        .clr            (clr),
        .stall_in       (stall_in),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .req            (req),
        .rw             (rw),
        .uncached       (uncached),
        .data_out       (data_out),
        .ready          (ready),
        .addr_out       (addr_out),
        .bus_addr       (bus_addr),
        .bus_data       (bus_data),
        .bus_dma        (bus_dma),
        .bus_rw         (bus_rw),
        .bus_grant      (bus_grant),
        .bus_ready      (bus_ready),
        .dbg_we_a       (dbg_we_a),
        .dbg_we_b       (dbg_we_b),
        .dbg_we_c       (dbg_we_c),
        .dbg_needupdate (dbg_needupdate),
        .dbg_tag        (dbg_tag),
        .dbg_hit_a      (dbg_hit_a),
        .dbg_hit_b      (dbg_hit_b),
        .dbg_ram_a      (dbg_ram_a),
        .dbg_ram_b      (dbg_ram_b),
        .dbg_lru        (dbg_lru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU stalls while the current access is incomplete.
    assign stall_in = !ready;

    // bus_control: grant follows the request one cycle later.
    // dummy_slave: completes a transfer on the third granted cycle.
    logic [31:0] mem [64];
    int          scnt;
    logic        tb_probe;

    always @(posedge clk) begin
        bus_grant <= bus_dma;
        if (!bus_grant) scnt <= 0;
        else if (scnt < 4) scnt <= scnt + 1;
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + i;
        end else if (bus_ready && bus_rw === 1'b1) begin
            mem[bus_addr[7:2]] <= bus_data;
        end
    end

    assign bus_ready = (scnt == 3);
    assign bus_data  = (bus_ready && bus_rw !== 1'b1) ? mem[bus_addr[7:2]] : 32'bz;
    assign bus_addr  = tb_probe ? 32'h5A5A_0000 : 32'bz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs the current access to completion and records what happened on the way.
    task automatic finish(output logic [31:0] d, output int cyc, output logic s_dma,
                          output logic s_wa, output logic s_wb, output logic s_wr,
                          output logic s_ha, output logic s_hb, output logic s_lru,
                          output logic ok);
        d = '0; cyc = 0; s_dma = 0; s_wa = 0; s_wb = 0; s_wr = 0;
        s_ha = 0; s_hb = 0; s_lru = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_dma) s_dma = 1;
            if (dbg_we_a) s_wa = 1;
            if (dbg_we_b) s_wb = 1;
            if (bus_ready && bus_rw === 1'b1) s_wr = 1;
            if (ready) begin
                d = data_out; s_ha = dbg_hit_a; s_hb = dbg_hit_b; s_lru = dbg_lru;
                ok = 1;
                break;
            end
            cyc++;
        end
    endtask

    // Presents the next address while ready is high, then the access attributes.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic u);
        addr_in = a;
        @(posedge clk);
        #1;
        rw = w; data_in = d; uncached = u;
    endtask

    logic [31:0] d;
    int          cyc;
    logic        s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok;
    logic        found;

    initial begin
        clr = 1; req = 1; rw = 0; uncached = 0; addr_in = 0; data_in = 0; tb_probe = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_out", addr_out, 32'h0);
        chk("rst_bus_dma", bus_dma, 0);
        chk("rst_needupdate", dbg_needupdate, 0);
        chk("rst_hit_a", dbg_hit_a, 0);
        chk("rst_ready", ready, 0);
        clr = 0;

        // read 0: cold miss, fill way A
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r0_done", ok, 1); chk("r0_data", d, 32'hC0DE_0000);
        chk("r0_dma", s_dma, 1); chk("r0_we_a", s_wa, 1); chk("r0_we_b", s_wb, 0);
        issue(32'd4, 0, 0, 0);

        // read 4: cold miss set 1, fill way A, full miss latency
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r4_data", d, 32'hC0DE_0001); chk("r4_we_a", s_wa, 1); chk("r4_cyc", cyc, 6);
        issue(32'd28, 0, 0, 0);

        // read 28: set 1 way A taken -> way B
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r28_data", d, 32'hC0DE_0007); chk("r28_we_b", s_wb, 1); chk("r28_we_a", s_wa, 0);
        issue(32'd8, 0, 0, 0);

        // read 8: set 0 way B
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r8_data", d, 32'hC0DE_0002); chk("r8_we_b", s_wb, 1);
        issue(32'd16, 0, 0, 0);

        // read 16: set 0 full, LRU names A -> evict 0 from way A
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r16_data", d, 32'hC0DE_0004); chk("r16_we_a", s_wa, 1);
        chk("r16_we_b", s_wb, 0); chk("r16_lru", s_lru, 0);
        issue(32'd4, 0, 0, 0);

        // re-read 4: hit way A, same cycle, no bus; LRU[1] points at A after 28
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("h4_cyc", cyc, 0); chk("h4_dma", s_dma, 0); chk("h4_hit_a", s_ha, 1);
        chk("h4_data", d, 32'hC0DE_0001); chk("h4_lru", s_lru, 0);
        issue(32'd0, 0, 0, 0);

        // re-read 0: evicted -> miss, LRU now names B
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("m0_dma", s_dma, 1); chk("m0_we_b", s_wb, 1); chk("m0_data", d, 32'hC0DE_0000);
        issue(32'd4, 1, 32'h0AB2_1128, 0);

        // write hit 4: bus write plus way A update
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("w4_done", ok, 1); chk("w4_bus_rw", s_wr, 1); chk("w4_we_a", s_wa, 1);
        chk("w4_we_b", s_wb, 0); chk("w4_mem", mem[1], 32'h0AB2_1128);
        issue(32'd4, 0, 0, 0);

        // read 4 after write: hit returns the written word
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("rw4_cyc", cyc, 0); chk("rw4_data", d, 32'h0AB2_1128);
        issue(32'd12, 0, 0, 1);

        // uncached read 12: bus only, no array write
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("u12_data", d, 32'hC0DE_0003); chk("u12_dma", s_dma, 1);
        chk("u12_we", {s_wa, s_wb}, 2'b00); chk("u12_cyc", cyc, 6);
        issue(32'd28, 0, 0, 0);

        // read 28: still resident in way B (bypass allocated nothing)
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("h28_cyc", cyc, 0); chk("h28_hit_b", s_hb, 1); chk("h28_data", d, 32'hC0DE_0007);
        issue(32'd20, 1, 32'h0000_0055, 0);

        // write miss 20: bus write, no allocate
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("w20_we", {s_wa, s_wb}, 2'b00); chk("w20_bus_rw", s_wr, 1);
        chk("w20_mem", mem[5], 32'h0000_0055);
        issue(32'd20, 0, 0, 0);

        // read 20: miss (not allocated by the write), returns the written word
        finish(d, cyc, s_dma, s_wa, s_wb, s_wr, s_ha, s_hb, s_lru, ok);
        chk("r20_dma", s_dma, 1); chk("r20_data", d, 32'h0000_0055);
        issue(32'd36, 0, 0, 0);

        // clr during XFER of a read of 36
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_grant && dbg_needupdate) begin
                found = 1;
                break;
            end
        end
        chk("clr_grant_seen", found, 1);
        @(negedge clk);
        chk("xfer_bus_addr", bus_addr, 32'd36);
        chk("xfer_needupdate", dbg_needupdate, 1);
        clr = 1;
        @(negedge clk);
        chk("clr_bus_dma", bus_dma, 0);
        chk("clr_needupdate", dbg_needupdate, 0);
        chk("clr_addr_out", addr_out, 32'h0);
        chk("clr_hit", {dbg_hit_a, dbg_hit_b}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        tb_probe = 1;
        #1;
        chk("clr_bus_released", bus_addr, 32'h5A5A_0000);
        @(negedge clk);
        tb_probe = 0;
        clr = 0; req = 0; addr_in = 32'd4;
        #1;
        chk("idle_ready", ready, 1);
        @(negedge clk);
        chk("post_clr_addr", addr_out, 32'd4);
        chk("post_clr_hit", {dbg_hit_a, dbg_hit_b}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
